// File: rtl/sorted_unpacker.sv
// Ping-pong drain buffer behind the bitonic sorter. It streams each sorted vector
// out as narrow beats and raises sticky flags for key-order violations and dropped vectors.
module sorted_unpacker #(
  parameter int P_LOG = 9,
  parameter int DATW  = 64,
  parameter int KEYW  = 32,
  parameter int O_LOG = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [(DATW<<P_LOG)-1:0]  DIN,
  input  logic                      DINEN,
  output logic                      DIN_RDY,
  output logic [(DATW<<O_LOG)-1:0]  DOT,
  output logic                      DOTEN,
  input  logic                      DOT_RDY,
  output logic                      DOT_LAST,
  output logic                      ERR,
  output logic                      OVF
);

  localparam int VW   = DATW << P_LOG;
  localparam int BW   = DATW << O_LOG;
  localparam int NREC = 1 << O_LOG;
  localparam int NB   = 1 << (P_LOG - O_LOG);
  localparam int BIW  = (P_LOG > O_LOG) ? (P_LOG - O_LOG) : 1;

  logic [VW-1:0]   buf_mem [2];
  logic            wp_reg, rp_reg;
  logic [1:0]      cnt_reg, cnt_next;
  logic [BIW-1:0]  bi_reg;
  logic [KEYW-1:0] prev_key_reg;
  logic [BW-1:0]   dot_reg;
  logic            doten_reg, last_reg, err_reg, ovf_reg;

  logic            wr_en, load, last_beat;
  logic [BW-1:0]   beat;
  logic [KEYW-1:0] key [NREC];
  logic [NREC-1:0] bad;

  assign wr_en     = DINEN && (cnt_reg != 2'd2);
  assign load      = (!doten_reg || DOT_RDY) && (cnt_reg != 2'd0);
  assign last_beat = (bi_reg == BIW'(NB - 1));
  assign beat      = buf_mem[rp_reg][int'(bi_reg)*BW +: BW];

  // bad[0] is the cross-beat check, skipped on the first beat of each vector.
  assign bad[0] = (bi_reg != '0) && (key[0] < prev_key_reg);

  generate
    for (genvar gi = 0; gi < NREC; gi++) begin : g_key
      assign key[gi] = beat[gi*DATW +: KEYW];
    end
    for (genvar gi = 1; gi < NREC; gi++) begin : g_inbeat
      assign bad[gi] = key[gi] < key[gi-1];
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg;
    case ({wr_en, load && last_beat})
      2'b10:   cnt_next = cnt_reg + 2'd1;
      2'b01:   cnt_next = cnt_reg - 2'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_en && !RST)
      buf_mem[wp_reg] <= DIN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_reg       <= 1'b0;
      rp_reg       <= 1'b0;
      cnt_reg      <= 2'd0;
      bi_reg       <= '0;
      prev_key_reg <= '0;
      dot_reg      <= '0;
      doten_reg    <= 1'b0;
      last_reg     <= 1'b0;
      err_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (wr_en)
        wp_reg <= ~wp_reg;
      else if (DINEN)
        ovf_reg <= 1'b1;

      if (load) begin
        dot_reg      <= beat;
        doten_reg    <= 1'b1;
        last_reg     <= last_beat;
        prev_key_reg <= key[NREC-1];
        if (|bad)
          err_reg <= 1'b1;
        if (last_beat) begin
          bi_reg <= '0;
          rp_reg <= ~rp_reg;
        end else begin
          bi_reg <= bi_reg + 1'b1;
        end
      end else if (DOT_RDY) begin
        doten_reg <= 1'b0;
      end
    end
  end

  assign DIN_RDY  = (cnt_reg != 2'd2);
  assign DOT      = dot_reg;
  assign DOTEN    = doten_reg;
  assign DOT_LAST = last_reg;
  assign ERR      = err_reg;
  assign OVF      = ovf_reg;

endmodule

// File: tb/tb_sorted_unpacker.sv
// Scoreboard bench for sorted_unpacker: one instance with single-record beats, one with two-record beats.
// Stimulus pushes expected beats; the negedge monitors pop and compare on every DOTEN && DOT_RDY.
module tb_sorted_unpacker;

  localparam int P_LOG = 3;
  localparam int DATW  = 64;
  localparam int KEYW  = 32;

  typedef int unsigned keys_t [8];
  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] din;
  logic         dinen_a, rdy_a, dinen_b, rdy_b;
  logic         din_rdy_a, doten_a, last_a, err_a, ovf_a;
  logic         din_rdy_b, doten_b, last_b, err_b, ovf_b;
  logic [63:0]  dot_a;
  logic [127:0] dot_b;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sorted_unpacker #(.P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW), .O_LOG(0)) u_a (
    .CLK(clk), .RST(rst), .DIN(din), .DINEN(dinen_a), .DIN_RDY(din_rdy_a),
    .DOT(dot_a), .DOTEN(doten_a), .DOT_RDY(rdy_a), .DOT_LAST(last_a),
    .ERR(err_a), .OVF(ovf_a));

  sorted_unpacker #(.P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW), .O_LOG(1)) u_b (
    .CLK(clk), .RST(rst), .DIN(din), .DINEN(dinen_b), .DIN_RDY(din_rdy_b),
    .DOT(dot_b), .DOTEN(doten_b), .DOT_RDY(rdy_b), .DOT_LAST(last_b),
    .ERR(err_b), .OVF(ovf_b));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rec(input int unsigned k);
    return {32'hFFFF_FFFF, k};
  endfunction

  function automatic keys_t seq(input int unsigned b);
    keys_t k;
    for (int i = 0; i < 8; i++) k[i] = b + i;
    return k;
  endfunction

  function automatic logic [511:0] mk(input keys_t k);
    logic [511:0] v;
    for (int i = 0; i < 8; i++) v[i*64 +: 64] = rec(k[i]);
    return v;
  endfunction

  task automatic push_a(input keys_t k);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.data = {64'd0, rec(k[i])};
      e.last = (i == 7);
      exp_a.push_back(e);
    end
  endtask

  task automatic push_b(input keys_t k);
    exp_t e;
    for (int j = 0; j < 4; j++) begin
      e.data = {rec(k[2*j+1]), rec(k[2*j])};
      e.last = (j == 3);
      exp_b.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input bit sel);
    int n = 0;
    while (n < 100 && (sel ? (exp_b.size() != 0 || doten_b) : (exp_a.size() != 0 || doten_a))) begin
      tick();
      n++;
    end
    chk(sel ? "drain_b" : "drain_a", 128'(n < 100), 128'd1);
  endtask

  // Monitors: compare each accepted beat, and check that stalled beats hold steady.
  logic        hold_a = 1'b0, hold_b = 1'b0;
  logic [63:0] held_a;
  logic [127:0] held_b;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst) begin
      hold_a <= 1'b0;
    end else begin
      if (hold_a) chk("hold_a", {63'd0, doten_a, dot_a}, {63'd0, 1'b1, held_a});
      if (doten_a && rdy_a) begin
        if (exp_a.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_beat_a: got %h expected no beat", dot_a);
        end else begin
          e = exp_a.pop_front();
          chk("data_a", {64'd0, dot_a}, e.data);
          chk("last_a", {127'd0, last_a}, {127'd0, e.last});
          $display("a beat key=%0d last=%0d", dot_a[31:0], last_a);
        end
      end
      hold_a <= doten_a && !rdy_a;
      held_a <= dot_a;
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst) begin
      hold_b <= 1'b0;
    end else begin
      if (hold_b) chk("hold_b", {127'd0, doten_b}, 128'd1);
      if (hold_b) chk("hold_data_b", dot_b, held_b);
      if (doten_b && rdy_b) begin
        if (exp_b.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_beat_b: got %h expected no beat", dot_b);
        end else begin
          e = exp_b.pop_front();
          chk("data_b", dot_b, e.data);
          chk("last_b", {127'd0, last_b}, {127'd0, e.last});
          $display("b beat keys=%0d,%0d last=%0d", dot_b[31:0], dot_b[95:64], last_b);
        end
      end
      hold_b <= doten_b && !rdy_b;
      held_b <= dot_b;
    end
  end

  initial begin
    din = '0; dinen_a = 1'b0; dinen_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_doten", {127'd0, doten_a}, 128'd0);
    chk("rst_last", {127'd0, last_a}, 128'd0);
    chk("rst_dot", {64'd0, dot_a}, 128'd0);
    chk("rst_err", {127'd0, err_a}, 128'd0);
    chk("rst_ovf", {127'd0, ovf_a}, 128'd0);
    chk("rst_din_rdy", {127'd0, din_rdy_a}, 128'd1);
    chk("rst_doten_b", {127'd0, doten_b}, 128'd0);
    rst = 1'b0;
    tick();

    // Single vector, one record per beat: latency and streaming
    din = mk(seq(1)); push_a(seq(1)); dinen_a = 1'b1;
    tick(); dinen_a = 1'b0;
    chk("lat_edge_k", {127'd0, doten_a}, 128'd0);
    tick();
    chk("lat_edge_k1", {127'd0, doten_a}, 128'd1);
    chk("first_key", {96'd0, dot_a[31:0]}, 128'd1);
    wait_drain(1'b0);
    chk("t1_err", {127'd0, err_a}, 128'd0);
    chk("t1_ovf", {127'd0, ovf_a}, 128'd0);

    // Two records per beat with a toggling consumer
    din = mk(seq(1)); push_b(seq(1)); dinen_b = 1'b1;
    tick(); dinen_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rdy_b = ~rdy_b;
    end
    rdy_b = 1'b1;
    wait_drain(1'b1);
    chk("t2_err", {127'd0, err_b}, 128'd0);

    // Back-to-back identical vectors: 16 beats, no bubbles, no ERR
    din = mk(seq(1)); push_a(seq(1)); push_a(seq(1)); dinen_a = 1'b1;
    tick(); tick(); dinen_a = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk("b2b_doten", {127'd0, doten_a}, 128'd1);
      chk("b2b_last", {127'd0, last_a}, {127'd0, (i == 8 || i == 16)});
      if (i < 16) tick();
    end
    wait_drain(1'b0);
    chk("b2b_err", {127'd0, err_a}, 128'd0);

    // Overflow: third vector dropped while the consumer is stalled
    rdy_a = 1'b0;
    din = mk(seq(11)); push_a(seq(11)); dinen_a = 1'b1;
    tick();
    chk("ovf_rdy1", {127'd0, din_rdy_a}, 128'd1);
    din = mk(seq(21)); push_a(seq(21));
    tick();
    chk("ovf_rdy0", {127'd0, din_rdy_a}, 128'd0);
    chk("ovf_pre", {127'd0, ovf_a}, 128'd0);
    din = mk(seq(31));
    tick(); dinen_a = 1'b0;
    chk("ovf_set", {127'd0, ovf_a}, 128'd1);
    repeat (3) tick();
    rdy_a = 1'b1;
    wait_drain(1'b0);
    chk("ovf_err", {127'd0, err_a}, 128'd0);
    chk("ovf_rdy_back", {127'd0, din_rdy_a}, 128'd1);

    // Order violation: ERR rises on the edge that loads key 4
    din = mk('{1, 2, 3, 5, 4, 6, 7, 8}); push_a('{1, 2, 3, 5, 4, 6, 7, 8}); dinen_a = 1'b1;
    tick(); dinen_a = 1'b0;
    repeat (4) tick();
    chk("err_before", {127'd0, err_a}, 128'd0);
    tick();
    chk("err_at_key4", {127'd0, err_a}, 128'd1);
    wait_drain(1'b0);
    chk("err_sticky", {127'd0, err_a}, 128'd1);

    // Reset mid-drain at beat 3, with DINEN high during reset
    din = mk(seq(1)); push_a(seq(1)); dinen_a = 1'b1;
    tick(); dinen_a = 1'b0;
    repeat (4) tick();
    chk("mid_key", {96'd0, dot_a[31:0]}, 128'd4);
    rst = 1'b1; dinen_a = 1'b1;
    tick();
    exp_a.delete();
    rst = 1'b0; dinen_a = 1'b0;
    chk("mid_rst_doten", {127'd0, doten_a}, 128'd0);
    chk("mid_rst_rdy", {127'd0, din_rdy_a}, 128'd1);
    chk("mid_rst_err", {127'd0, err_a}, 128'd0);
    chk("mid_rst_ovf", {127'd0, ovf_a}, 128'd0);
    tick();
    chk("rst_dinen_ignored", {127'd0, doten_a}, 128'd0);
    din = mk(seq(41)); push_a(seq(41)); dinen_a = 1'b1;
    tick(); dinen_a = 1'b0;
    tick();
    chk("post_rst_key", {96'd0, dot_a[31:0]}, 128'd41);
    wait_drain(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test expected end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sorted_unpacker.md
# sorted_unpacker

Drain-side companion of the BITONIC sorter: accepts one full sorted vector of 2^P_LOG records per DINEN pulse and streams it out as narrow beats of 2^O_LOG records under a valid/ready handshake. It double-buffers whole vectors so the sorter can deliver the next result while the current one drains. It also checks key order on the way out, raising sticky error and overflow flags. It sits between the sorter's DOT/DOTEN outputs and any narrow consumer (memory writer, host FIFO).

## Interface
- P_LOG, 9, log2 of records per input vector
- DATW, 64, record width in bits
- KEYW, 32, key width; key = low KEYW bits of each record
- O_LOG, 0, log2 of records per output beat; legal range 0..P_LOG
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- DIN  in  DATW<<P_LOG  sorted vector; record i at bits [DATW*(i+1)-1:DATW*i]
- DINEN  in  1  DIN valid for one cycle; no handshake on the sorter side
- DIN_RDY  out  1  at least one vector buffer free
- DOT  out  DATW<<O_LOG  output beat; record j of the beat at bits [DATW*(j+1)-1:DATW*j]
- DOTEN  out  1  DOT valid
- DOT_RDY  in  1  consumer accepts DOT this cycle
- DOT_LAST  out  1  DOT is the final beat of its vector
- ERR  out  1  sticky: key order violation seen
- OVF  out  1  sticky: DINEN while DIN_RDY low; vector dropped

## Operation
- Storage: two vector buffers in ping-pong, with write pointer wp, read pointer rp, occupancy cnt 0..2, and beat index bi 0..NB-1, where NB = 2^(P_LOG-O_LOG).
- DIN_RDY = (cnt != 2), driven directly from registers.
- Write: DINEN && DIN_RDY → buf[wp] <= DIN, wp toggles, cnt+1.
- DINEN && !DIN_RDY → DIN discarded and OVF set; no buffer or pointer changes.
- Output stage: a single register holding DOT, DOTEN and DOT_LAST.
  - Load condition: (!DOTEN || DOT_RDY) && cnt != 0.
  - On load: DOT <= beat bi of buf[rp], meaning records bi*2^O_LOG .. bi*2^O_LOG+2^O_LOG-1. DOTEN <= 1. DOT_LAST <= (bi == NB-1).
  - After the load, bi advances. On bi == NB-1, bi wraps to 0, rp toggles and cnt-1 (buffer freed on load of the last beat).
- DOTEN && DOT_RDY with nothing to load → DOTEN <= 0.
- DOTEN && !DOT_RDY → DOT, DOTEN and DOT_LAST hold unchanged.
- Write and free in the same cycle → cnt unchanged. A write is accepted when cnt == 2 only if DIN_RDY was high, so a free in the same cycle does not rescue it.
- Order check runs on each loaded beat:
  - Keys within the beat must be nondecreasing.
  - The first key of the beat must be ≥ prev_key, except on the first beat of a vector (bi == 0), which skips the cross-beat compare.
  - prev_key <= last key of the beat.
  - A violation sets ERR on the same edge as the load. The comparison is unsigned.
- ERR and OVF clear only on RST.
- Data is passed through unmodified; the check never alters DOT.

## Timing
- Reset values: DIN_RDY=1 (cnt=0), DOTEN=0, DOT_LAST=0, DOT=0, ERR=0, OVF=0. Also wp=rp=bi=0 and prev_key=0.
- RST mid-stream drops both buffers and any beat in flight. DINEN in a cycle where RST is high is ignored.
- Latency: DINEN sampled at edge k with cnt==0 → DOTEN=1 with beat 0 after edge k+1.
- Throughput with DOT_RDY held high: one beat per cycle, no bubbles between back-to-back vectors while cnt > 0.
- A vector drains in NB cycles. A DINEN period ≥ NB never overflows with DOT_RDY high.
- DIN_RDY rises the cycle after the edge that loads the last beat of the older buffer.

## Test plan
- P_LOG=3, O_LOG=0, keys 1..8 (record bits 63:32 all ones), one DINEN, DOT_RDY=1 → DOTEN after edge k+1. DOT keys 1,2,...,8 on 8 consecutive cycles. DOT_LAST only with key 8. ERR=0, OVF=0.
- P_LOG=3, O_LOG=1, DOT_RDY toggling 1,0,1,0 → beats {1,2},{3,4},{5,6},{7,8}. Each beat held stable while DOT_RDY=0. No beat lost or repeated.
- P_LOG=3, O_LOG=0, DOT_RDY=0, three DINEN pulses on consecutive cycles → DIN_RDY low after the 2nd write, OVF=1 after the 3rd. Releasing DOT_RDY then streams exactly 16 records: vector 1, then vector 2.
- Vector keys 1,2,3,5,4,6,7,8 → ERR set on the edge loading key 4, ERR stays 1. All 8 records are still output unchanged.
- Two back-to-back vectors: keys 1..8, then keys 1..8 again → no ERR, because the cross-vector compare is skipped at bi==0. 16 consecutive DOTEN cycles with DOT_LAST at cycles 8 and 16.
- RST asserted mid-drain at beat 3 → next cycle DOTEN=0, DIN_RDY=1, ERR=0, OVF=0. A new vector afterwards is output from beat 0.
